// File: rtl/cpu_pkg.sv
// Shared definitions for the decode-side operand stage.
// Holds register-file geometry, datapath width, immediate field widths,
// the forwarding-source enumeration and the immediate extension helper.
package cpu_pkg;

    localparam int NREG    = 16;
    localparam int AW      = 4;
    localparam int DW      = 32;
    localparam int PCW     = 16;
    localparam int IMM12_W = 12;
    localparam int IMM5_W  = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_WB = 2'd1,
        FWD_EX = 2'd2
    } fwd_sel_t;

    // Sign- or zero-extend the raw 12-bit immediate to the datapath width.
    function automatic logic [DW-1:0] ext_imm12(input logic [IMM12_W-1:0] imm,
                                                input logic               sgn);
        logic [DW-1:0] r;
        if (sgn) r = {{(DW-IMM12_W){imm[IMM12_W-1]}}, imm};
        else     r = {{(DW-IMM12_W){1'b0}}, imm};
        return r;
    endfunction

endpackage

// File: rtl/id_operand_stage_if.sv
// Bundle of every non-clock signal of the operand stage.
//   in_*     : decoded instruction and its accept handshake (in_ready)
//   ex_*     : state of the instruction currently in EX
//   wb_*     : register-file write port from writeback
//   flush    : kill the instruction entering EX
//   out_*    : ID/EX pipeline register contents
//   perf_bubbles : saturating load-use bubble count
// master = the surrounding pipeline / bench, slave = the operand stage.
interface id_operand_stage_if;
    import cpu_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [AW-1:0]        in_ra;
    logic [AW-1:0]        in_rb;
    logic [AW-1:0]        in_rd;
    logic                 in_rd_wen;
    logic                 in_immed_sel;
    logic [IMM12_W-1:0]   in_imm12;
    logic                 in_imm_signed;
    logic [IMM5_W-1:0]    in_immed5;
    logic                 ex_stall;
    logic                 ex_load;
    logic [DW-1:0]        ex_result;
    logic                 wb_wen;
    logic [AW-1:0]        wb_addr;
    logic [DW-1:0]        wb_data;
    logic                 flush;
    logic                 out_valid;
    logic [DW-1:0]        out_srcA;
    logic [DW-1:0]        out_srcB;
    logic [DW-1:0]        out_immed32;
    logic [IMM5_W-1:0]    out_immed5;
    logic                 out_immed_sel;
    logic [AW-1:0]        out_rd;
    logic                 out_rd_wen;
    logic [PCW-1:0]       perf_bubbles;

    modport master (
        output in_valid, in_ra, in_rb, in_rd, in_rd_wen, in_immed_sel,
               in_imm12, in_imm_signed, in_immed5,
               ex_stall, ex_load, ex_result, wb_wen, wb_addr, wb_data, flush,
        input  in_ready, out_valid, out_srcA, out_srcB, out_immed32,
               out_immed5, out_immed_sel, out_rd, out_rd_wen, perf_bubbles
    );

    modport slave (
        input  in_valid, in_ra, in_rb, in_rd, in_rd_wen, in_immed_sel,
               in_imm12, in_imm_signed, in_immed5,
               ex_stall, ex_load, ex_result, wb_wen, wb_addr, wb_data, flush,
        output in_ready, out_valid, out_srcA, out_srcB, out_immed32,
               out_immed5, out_immed_sel, out_rd, out_rd_wen, perf_bubbles
    );

endinterface

// File: rtl/id_operand_stage_reg_file.sv
// Architectural register file: NREG x DW, one write port, two combinational
// read ports. A write in the same cycle as a read of the same address is
// returned on the read port (write-through). Asynchronous clear to zero.
//   clk, resetn        : clock / async active-low reset
//   we_i, wa_i, wd_i   : write port
//   ra_a_i, rd_a_o     : read port A
//   ra_b_i, rd_b_o     : read port B
module reg_file
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [DW-1:0] wd_i,
    input  logic [AW-1:0] ra_a_i,
    output logic [DW-1:0] rd_a_o,
    input  logic [AW-1:0] ra_b_i,
    output logic [DW-1:0] rd_b_o
);

    logic [DW-1:0] regs_q [NREG];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd_a_o = (we_i && (wa_i == ra_a_i)) ? wd_i : regs_q[ra_a_i];
    assign rd_b_o = (we_i && (wa_i == ra_b_i)) ? wd_i : regs_q[ra_b_i];

endmodule

// File: rtl/id_operand_stage.sv
// Decode-side operand producer. Reads sources from the register file,
// forwards the EX and WB results, extends the immediate, and loads the
// ID/EX pipeline register. A load in EX whose destination matches either
// source of the incoming instruction inserts a one-cycle bubble; the load
// data then arrives through the WB forward.
//   clk, resetn : clock / async active-low reset
//   bus         : id_operand_stage_if.slave (all handshake and data signals)
module id_operand_stage
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    id_operand_stage_if.slave  bus
);

    logic [DW-1:0]     rf_a, rf_b;
    fwd_sel_t          sel_a, sel_b;
    logic [DW-1:0]     op_a, op_b;
    logic              ex_fwd_ok;
    logic              hazard;

    logic              out_valid_q;
    logic [DW-1:0]     out_srca_q;
    logic [DW-1:0]     out_srcb_q;
    logic [DW-1:0]     out_imm32_q;
    logic [IMM5_W-1:0] out_imm5_q;
    logic              out_sel_q;
    logic [AW-1:0]     out_rd_q;
    logic              out_rd_wen_q;
    logic [PCW-1:0]    bubbles_q;

    reg_file u_rf (
        .clk    (clk),
        .resetn (resetn),
        .we_i   (bus.wb_wen),
        .wa_i   (bus.wb_addr),
        .wd_i   (bus.wb_data),
        .ra_a_i (bus.in_ra),
        .rd_a_o (rf_a),
        .ra_b_i (bus.in_rb),
        .rd_b_o (rf_b)
    );

    // A load in EX has no result yet, so it is never a forwarding source.
    assign ex_fwd_ok = out_valid_q && out_rd_wen_q && !bus.ex_load;

    always_comb begin
        sel_a = FWD_RF;
        if (ex_fwd_ok && (out_rd_q == bus.in_ra))             sel_a = FWD_EX;
        else if (bus.wb_wen && (bus.wb_addr == bus.in_ra))    sel_a = FWD_WB;
        sel_b = FWD_RF;
        if (ex_fwd_ok && (out_rd_q == bus.in_rb))             sel_b = FWD_EX;
        else if (bus.wb_wen && (bus.wb_addr == bus.in_rb))    sel_b = FWD_WB;
    end

    always_comb begin
        case (sel_a)
            FWD_EX:  op_a = bus.ex_result;
            FWD_WB:  op_a = bus.wb_data;
            default: op_a = rf_a;
        endcase
        case (sel_b)
            FWD_EX:  op_b = bus.ex_result;
            FWD_WB:  op_b = bus.wb_data;
            default: op_b = rf_b;
        endcase
    end

    // rb is compared even for immediate-form instructions.
    assign hazard = bus.in_valid && out_valid_q && out_rd_wen_q && bus.ex_load &&
                    ((out_rd_q == bus.in_ra) || (out_rd_q == bus.in_rb));

    assign bus.in_ready = !bus.ex_stall && !hazard;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q  <= 1'b0;
            out_srca_q   <= '0;
            out_srcb_q   <= '0;
            out_imm32_q  <= '0;
            out_imm5_q   <= '0;
            out_sel_q    <= 1'b0;
            out_rd_q     <= '0;
            out_rd_wen_q <= 1'b0;
            bubbles_q    <= '0;
        end else if (bus.flush) begin
            out_valid_q  <= 1'b0;
        end else if (bus.ex_stall) begin
            out_valid_q  <= out_valid_q;
        end else if (hazard) begin
            out_valid_q  <= 1'b0;
            if (bubbles_q != {PCW{1'b1}}) bubbles_q <= bubbles_q + 1'b1;
        end else begin
            out_valid_q  <= bus.in_valid;
            out_srca_q   <= op_a;
            out_srcb_q   <= op_b;
            out_imm32_q  <= ext_imm12(bus.in_imm12, bus.in_imm_signed);
            out_imm5_q   <= bus.in_immed5;
            out_sel_q    <= bus.in_immed_sel;
            out_rd_q     <= bus.in_rd;
            out_rd_wen_q <= bus.in_rd_wen;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_srcA      = out_srca_q;
    assign bus.out_srcB      = out_srcb_q;
    assign bus.out_immed32   = out_imm32_q;
    assign bus.out_immed5    = out_imm5_q;
    assign bus.out_immed_sel = out_sel_q;
    assign bus.out_rd        = out_rd_q;
    assign bus.out_rd_wen    = out_rd_wen_q;
    assign bus.perf_bubbles  = bubbles_q;

endmodule
